mem_transmitter: RTL
====================

Name: mem_transmitter

Overview:
- Command-to-bus stage directly downstream of the test control FSM.
- Accepts one write/read command per handshake and issues it as an Avalon-MM burst to the memory under test.
- Generates the write-data pattern, limits outstanding read beats, and reports progress/busy status upstream.
- Read data goes straight from the bus to the compare block; this block only counts the returning beats.

Parameters:
- ADDR_W, 31, word address width (command and bus).
- DATA_W, 128, Avalon-MM data width; multiple of 32.
- BURST_W, 11, burstcount width; maximum burst = 2^(BURST_W-1) = 1024.
- MAX_RD_OUTSTANDING, 2048, maximum read beats in flight.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- start_test_i  in  1  one-cycle strobe; latch test parameters, reseed pattern
- test_param_i  in  [2:1][31:0]  CSR test parameters
- trans_valid_i  in  1  command valid from control FSM
- trans_type_i  in  1  0 = write, 1 = read
- trans_addr_i  in  ADDR_W  command start word address
- trans_process_o  out  1  command in progress; command accepted when trans_valid_i && !trans_process_o
- trans_busy_o  out  1  command in progress or read beats outstanding
- amm_address_o  out  ADDR_W  bus address
- amm_read_o  out  1  bus read request
- amm_write_o  out  1  bus write request
- amm_writedata_o  out  DATA_W  write data
- amm_byteenable_o  out  DATA_W/8  byte enables; constant all-ones
- amm_burstcount_o  out  BURST_W  burst length
- amm_waitrequest_i  in  1  slave stall
- amm_readdatavalid_i  in  1  read beat returned

Behaviour:
- Reset values: trans_process_o=0, amm_read_o=0, amm_write_o=0, outstanding counter=0, state IDLE_S, pattern register=1. All bus outputs are registered.
- Parameter latch on start_test_i:
  - burst_len = test_param_i[1][10:0]; 0 is treated as 1, values above 1024 are clamped to 1024.
  - data_mode = test_param_i[1][13:12].
  - seed = test_param_i[2].
- Acceptance: only in IDLE_S, when trans_valid_i && !trans_process_o.
  - Type, address and current burst_len are latched per command.
  - trans_process_o goes high on the next cycle, so the control FSM's updated command in that cycle is never double-accepted.
- States:
  - IDLE_S -> WRITE_S on accepted write. Bus outputs are driven from the next cycle: amm_write_o=1, address, burstcount, first pattern word.
  - IDLE_S -> RD_WAIT_S on accepted read.
  - WRITE_S: each cycle with amm_write_o && !amm_waitrequest_i consumes one beat and advances the pattern; writedata is held while stalled. After the last beat is accepted: amm_write_o=0, go to IDLE_S, trans_process_o=0 on the same edge.
  - RD_WAIT_S -> READ_S when outstanding + burst <= MAX_RD_OUTSTANDING. On entry: amm_read_o=1 with address and burstcount.
  - READ_S: amm_read_o is held until !amm_waitrequest_i. On that edge: amm_read_o=0, outstanding += burst, go to IDLE_S, trans_process_o=0.
- Outstanding counter (width BURST_W+1 or log2 MAX+1, whichever is larger):
  - Decrements by 1 on each amm_readdatavalid_i.
  - Simultaneous add and decrement gives a net of burst-1.
  - A readdatavalid while the counter is 0 is ignored (saturates at 0).
- trans_busy_o = (state != IDLE_S) || (outstanding != 0). Combinational from registers.
- Pattern, one 32-bit word P replicated across DATA_W/32 lanes:
  - Mode 00: fixed. P = seed.
  - Mode 01: incrementing. P = seed, then +1 per accepted beat, with 32-bit wrap.
  - Mode 10: LFSR. Galois x^32+x^22+x^2+x+1; seed 0 is replaced by 1; advances per accepted beat.
  - Mode 11: treated as mode 00.
  - The pattern continues across commands and is reseeded only by start_test_i.
- Reads never advance the pattern.
- start_test_i while trans_busy_o=1: parameters and pattern are reloaded immediately; the in-flight command keeps its latched burst. The control FSM never does this, so it is not a bench requirement beyond no-hang.
- rst_i mid-burst: the next edge deasserts amm_read_o/amm_write_o and clears outstanding; the bus slave is reset with the same rst_i.

Optional Feature:
- Macro MEM_TRANSMITTER_STAT_EN adds three 32-bit saturating outputs:
  - stat_wr_cnt_o: accepted write beats.
  - stat_rd_cnt_o: returned read beats.
  - stat_stall_cnt_o: cycles with (amm_read_o || amm_write_o) && amm_waitrequest_i.
- The counters clear on rst_i and on start_test_i.
- Without the macro these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Write burst: burst_len=4, mode 01, seed 0x10, write to addr 0x100, no waitrequest -> 4 write beats with P=0x10,0x11,0x12,0x13, burstcount=4; trans_process_o high for 5 cycles; a second write then continues from 0x14.
- Stalled write: waitrequest high on beats 2–3 for 3 cycles each -> writedata held stable, exactly 4 beats accepted, stall counter = 6 (STAT_EN).
- Read credit limit: MAX_RD_OUTSTANDING=8, burst_len=4, three reads with no readdatavalid -> third waits in RD_WAIT_S; one readdatavalid -> still waits; after 4 beats return -> issued; trans_busy_o falls only after all 12 beats return.
- Simultaneous events: read accepted on the same edge as a readdatavalid with outstanding=3, burst=4 -> outstanding=6.
- Edge params: burst field 0 -> burstcount 1; burst field 2047 -> 1024; mode 10 with seed 0 -> first P=0x00000001.
- Reset mid-write at beat 2 of 8 -> amm_write_o=0 and trans_busy_o=0 on the next cycle; a following command runs normally.

Source files
------------

// File: rtl/mem_transmitter.sv
// Command-to-bus stage: turns write/read commands into Avalon-MM bursts and
// generates write patterns. Optional stats counters: MEM_TRANSMITTER_STAT_EN.
module mem_transmitter #(
  parameter int ADDR_W             = 31,
  parameter int DATA_W             = 128,
  parameter int BURST_W            = 11,
  parameter int MAX_RD_OUTSTANDING = 2048
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_test_i,
  input  logic [2:1][31:0]      test_param_i,
  input  logic                  trans_valid_i,
  input  logic                  trans_type_i,
  input  logic [ADDR_W-1:0]     trans_addr_i,
  output logic                  trans_process_o,
  output logic                  trans_busy_o,
  output logic [ADDR_W-1:0]     amm_address_o,
  output logic                  amm_read_o,
  output logic                  amm_write_o,
  output logic [DATA_W-1:0]     amm_writedata_o,
  output logic [DATA_W/8-1:0]   amm_byteenable_o,
  output logic [BURST_W-1:0]    amm_burstcount_o,
  input  logic                  amm_waitrequest_i,
  input  logic                  amm_readdatavalid_i
`ifdef MEM_TRANSMITTER_STAT_EN
  ,
  output logic [31:0]           stat_wr_cnt_o,
  output logic [31:0]           stat_rd_cnt_o,
  output logic [31:0]           stat_stall_cnt_o
`endif
);

  localparam int NUM_LANES = DATA_W / 32;
  localparam int OUT_W = (BURST_W + 1 > $clog2(MAX_RD_OUTSTANDING) + 1) ?
                         BURST_W + 1 : $clog2(MAX_RD_OUTSTANDING) + 1;
  localparam logic [31:0] MAX_BURST = 32'(1) << (BURST_W - 1);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE_S, WRITE_S, RD_WAIT_S, READ_S} state_t;

  state_t               state_q, state_d;
  logic [BURST_W-1:0]   burst_len_q, cmd_burst_q, beats_left_q, burst_new;
  logic [1:0]           mode_q;
  logic [31:0]          pat_q, pat_next, pat_src, seed_new;
  logic [ADDR_W-1:0]    cmd_addr_q;
  logic [OUT_W-1:0]     outst_q;
  logic [OUT_W:0]       credit_sum;
  logic                 accept, wr_start, wr_beat, wr_last, rd_issue, rd_done, rdv_dec;
  logic [NUM_LANES-1:0][31:0] wd_lanes;
  logic                 unused_param_bits;

  assign unused_param_bits = ^{test_param_i[1][31:14], test_param_i[1][11]};

  assign amm_byteenable_o = '1;
  assign trans_busy_o     = (state_q != IDLE_S) || (outst_q != '0);
  assign credit_sum       = {1'b0, outst_q} + (OUT_W+1)'(cmd_burst_q);
  assign rdv_dec          = amm_readdatavalid_i && (outst_q != '0);

  // Burst field: 0 means a single beat, oversize requests clamp to the bus maximum.
  always_comb begin
    burst_new = BURST_W'(test_param_i[1][10:0]);
    if (test_param_i[1][10:0] == 11'd0)
      burst_new = BURST_W'(1);
    else if (32'(test_param_i[1][10:0]) > MAX_BURST)
      burst_new = BURST_W'(MAX_BURST);
  end

  assign seed_new = (test_param_i[1][13:12] == 2'b10 && test_param_i[2] == 32'd0) ?
                    32'd1 : test_param_i[2];

  always_comb begin
    pat_next = pat_q;
    case (mode_q)
      2'b01:   pat_next = pat_q + 32'd1;
      2'b10:   pat_next = {1'b0, pat_q[31:1]} ^ (pat_q[0] ? LFSR_MASK : 32'd0);
      default: pat_next = pat_q;
    endcase
  end

  assign pat_src = wr_beat ? pat_next : pat_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wd_lanes[l] = pat_src;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_start = 1'b0;
    wr_beat  = 1'b0;
    wr_last  = 1'b0;
    rd_issue = 1'b0;
    rd_done  = 1'b0;
    case (state_q)
      IDLE_S: if (trans_valid_i && !trans_process_o) begin
        accept  = 1'b1;
        state_d = trans_type_i ? RD_WAIT_S : WRITE_S;
      end
      // First WRITE_S cycle only loads the bus registers.
      WRITE_S: if (!amm_write_o) begin
        wr_start = 1'b1;
      end else if (!amm_waitrequest_i) begin
        wr_beat = 1'b1;
        if (beats_left_q == BURST_W'(1)) begin
          wr_last = 1'b1;
          state_d = IDLE_S;
        end
      end
      RD_WAIT_S: if (credit_sum <= (OUT_W+1)'(MAX_RD_OUTSTANDING)) begin
        rd_issue = 1'b1;
        state_d  = READ_S;
      end
      READ_S: if (!amm_waitrequest_i) begin
        rd_done = 1'b1;
        state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE_S;
      trans_process_o  <= 1'b0;
      amm_read_o       <= 1'b0;
      amm_write_o      <= 1'b0;
      amm_address_o    <= '0;
      amm_burstcount_o <= '0;
      amm_writedata_o  <= '0;
      outst_q          <= '0;
      pat_q            <= 32'd1;
      mode_q           <= 2'b00;
      burst_len_q      <= BURST_W'(1);
      cmd_burst_q      <= BURST_W'(1);
      cmd_addr_q       <= '0;
      beats_left_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_addr_q      <= trans_addr_i;
        cmd_burst_q     <= burst_len_q;
        trans_process_o <= 1'b1;
      end
      if (wr_last || rd_done) trans_process_o <= 1'b0;
      if (wr_start) begin
        amm_write_o      <= 1'b1;
        amm_address_o    <= cmd_addr_q;
        amm_burstcount_o <= cmd_burst_q;
        beats_left_q     <= cmd_burst_q;
        amm_writedata_o  <= wd_lanes;
      end
      if (wr_beat) begin
        beats_left_q    <= beats_left_q - BURST_W'(1);
        amm_writedata_o <= wd_lanes;
        pat_q           <= pat_next;
      end
      if (wr_last) amm_write_o <= 1'b0;
      if (rd_issue) begin
        amm_read_o       <= 1'b1;
        amm_address_o    <= cmd_addr_q;
        amm_burstcount_o <= cmd_burst_q;
      end
      if (rd_done) amm_read_o <= 1'b0;
      outst_q <= outst_q + (rd_done ? OUT_W'(cmd_burst_q) : '0) - OUT_W'(rdv_dec);
      // A new test reloads immediately; an in-flight command keeps cmd_burst_q.
      if (start_test_i) begin
        burst_len_q <= burst_new;
        mode_q      <= test_param_i[1][13:12];
        pat_q       <= seed_new;
      end
    end
  end

`ifdef MEM_TRANSMITTER_STAT_EN
  logic stall_cyc;
  assign stall_cyc = (amm_read_o || amm_write_o) && amm_waitrequest_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_test_i) begin
      stat_wr_cnt_o    <= '0;
      stat_rd_cnt_o    <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (wr_beat && stat_wr_cnt_o != '1)               stat_wr_cnt_o    <= stat_wr_cnt_o + 32'd1;
      if (amm_readdatavalid_i && stat_rd_cnt_o != '1)   stat_rd_cnt_o    <= stat_rd_cnt_o + 32'd1;
      if (stall_cyc && stat_stall_cnt_o != '1)          stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
